// File: rtl/alu_rs_station.sv
// ALU reservation station: buffers dispatched ALU ops, snoops the ALU/LSB result buses, issues one ready op per cycle.
// Optional macro RS_FWD_EN lets a same-cycle broadcast make an operand ready and feed the dispatched value directly.
module alu_rs_station #(
    parameter int RS_SIZE   = 16,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 issue_valid,
    input  logic [6:0]           issue_op,
    input  logic [31:0]          issue_pc,
    input  logic [31:0]          issue_imm,
    input  logic [31:0]          issue_vj,
    input  logic [31:0]          issue_vk,
    input  logic [TAG_WIDTH-1:0] issue_qj,
    input  logic [TAG_WIDTH-1:0] issue_qk,
    input  logic                 issue_rj,
    input  logic                 issue_rk,
    input  logic [TAG_WIDTH-1:0] issue_dest,
    output logic                 rs_full,
    input  logic                 alu_valid_in,
    input  logic [TAG_WIDTH-1:0] alu_name_in,
    input  logic [31:0]          alu_result_in,
    input  logic                 lsb_valid_in,
    input  logic [TAG_WIDTH-1:0] lsb_name_in,
    input  logic [31:0]          lsb_result_in,
    output logic                 exec_valid,
    output logic [6:0]           exec_op,
    output logic [31:0]          exec_pc,
    output logic [31:0]          exec_rs1,
    output logic [31:0]          exec_rs2,
    output logic [31:0]          exec_imm,
    output logic [TAG_WIDTH-1:0] exec_name
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0]   busy, rj, rk;
    logic [6:0]           e_op   [RS_SIZE];
    logic [31:0]          e_pc   [RS_SIZE];
    logic [31:0]          e_imm  [RS_SIZE];
    logic [31:0]          e_vj   [RS_SIZE];
    logic [31:0]          e_vk   [RS_SIZE];
    logic [TAG_WIDTH-1:0] e_qj   [RS_SIZE];
    logic [TAG_WIDTH-1:0] e_qk   [RS_SIZE];
    logic [TAG_WIDTH-1:0] e_dest [RS_SIZE];

    logic [RS_SIZE-1:0]   hit_j, hit_k, ready;
    logic [31:0]          bus_j [RS_SIZE];
    logic [31:0]          bus_k [RS_SIZE];
    logic [IDX_W-1:0]     free_idx, sel_idx;
    logic                 any_ready, active, do_issue;
    logic [31:0]          iss_vj, iss_vk, disp_vj, disp_vk;
    logic                 iss_rj, iss_rk;

    assign rs_full  = &busy;
    assign active   = rdy_in & ~clear;
    assign do_issue = active & issue_valid & ~rs_full;

    // Per-entry bus snoop; the ALU bus has priority when both tags match.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            hit_j[i] = 1'b0;
            bus_j[i] = lsb_result_in;
            hit_k[i] = 1'b0;
            bus_k[i] = lsb_result_in;
            if (alu_valid_in && e_qj[i] == alu_name_in) begin
                hit_j[i] = 1'b1;
                bus_j[i] = alu_result_in;
            end else if (lsb_valid_in && e_qj[i] == lsb_name_in) begin
                hit_j[i] = 1'b1;
            end
            if (alu_valid_in && e_qk[i] == alu_name_in) begin
                hit_k[i] = 1'b1;
                bus_k[i] = alu_result_in;
            end else if (lsb_valid_in && e_qk[i] == lsb_name_in) begin
                hit_k[i] = 1'b1;
            end
`ifdef RS_FWD_EN
            ready[i] = busy[i] & (rj[i] | hit_j[i]) & (rk[i] | hit_k[i]);
`else
            ready[i] = busy[i] & rj[i] & rk[i];
`endif
        end
    end

    always_comb begin
        sel_idx  = '0;
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) sel_idx = IDX_W'(i);
            if (!busy[i]) free_idx = IDX_W'(i);
        end
        any_ready = |ready;
    end

    always_comb begin
        iss_vj = issue_vj;
        iss_rj = issue_rj;
        iss_vk = issue_vk;
        iss_rk = issue_rk;
        if (!issue_rj) begin
            if (alu_valid_in && issue_qj == alu_name_in) begin
                iss_vj = alu_result_in;
                iss_rj = 1'b1;
            end else if (lsb_valid_in && issue_qj == lsb_name_in) begin
                iss_vj = lsb_result_in;
                iss_rj = 1'b1;
            end
        end
        if (!issue_rk) begin
            if (alu_valid_in && issue_qk == alu_name_in) begin
                iss_vk = alu_result_in;
                iss_rk = 1'b1;
            end else if (lsb_valid_in && issue_qk == lsb_name_in) begin
                iss_vk = lsb_result_in;
                iss_rk = 1'b1;
            end
        end
    end

    always_comb begin
        disp_vj = e_vj[sel_idx];
        disp_vk = e_vk[sel_idx];
`ifdef RS_FWD_EN
        if (!rj[sel_idx]) disp_vj = bus_j[sel_idx];
        if (!rk[sel_idx]) disp_vk = bus_k[sel_idx];
`endif
    end

    // Control state and the exec register stage.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy       <= '0;
            rj         <= '0;
            rk         <= '0;
            exec_valid <= 1'b0;
            exec_op    <= '0;
            exec_pc    <= '0;
            exec_rs1   <= '0;
            exec_rs2   <= '0;
            exec_imm   <= '0;
            exec_name  <= '0;
        end else if (!rdy_in) begin
            exec_valid <= 1'b0;
        end else if (clear) begin
            busy       <= '0;
            exec_valid <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && !rj[i] && hit_j[i]) rj[i] <= 1'b1;
                if (busy[i] && !rk[i] && hit_k[i]) rk[i] <= 1'b1;
            end
            if (any_ready) busy[sel_idx] <= 1'b0;
            if (do_issue) begin
                busy[free_idx] <= 1'b1;
                rj[free_idx]   <= iss_rj;
                rk[free_idx]   <= iss_rk;
            end
            exec_valid <= any_ready;
            if (any_ready) begin
                exec_op   <= e_op[sel_idx];
                exec_pc   <= e_pc[sel_idx];
                exec_rs1  <= disp_vj;
                exec_rs2  <= disp_vk;
                exec_imm  <= e_imm[sel_idx];
                exec_name <= e_dest[sel_idx];
            end
        end
    end

    // Entry payload: no reset needed, busy qualifies every field.
    always_ff @(posedge clk_in) begin
        if (active) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && !rj[i] && hit_j[i]) e_vj[i] <= bus_j[i];
                if (busy[i] && !rk[i] && hit_k[i]) e_vk[i] <= bus_k[i];
            end
            if (do_issue) begin
                e_op[free_idx]   <= issue_op;
                e_pc[free_idx]   <= issue_pc;
                e_imm[free_idx]  <= issue_imm;
                e_vj[free_idx]   <= iss_vj;
                e_vk[free_idx]   <= iss_vk;
                e_qj[free_idx]   <= issue_qj;
                e_qk[free_idx]   <= issue_qk;
                e_dest[free_idx] <= issue_dest;
            end
        end
    end
endmodule

// File: tb/tb_alu_rs_station.sv
// Directed bench for alu_rs_station: one task per scenario, hand-computed expectations.
module tb_alu_rs_station;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, issue_valid;
    logic [6:0]  issue_op;
    logic [31:0] issue_pc, issue_imm, issue_vj, issue_vk;
    logic [4:0]  issue_qj, issue_qk, issue_dest;
    logic        issue_rj, issue_rk, rs_full;
    logic        alu_valid_in, lsb_valid_in;
    logic [4:0]  alu_name_in, lsb_name_in;
    logic [31:0] alu_result_in, lsb_result_in;
    logic        exec_valid;
    logic [6:0]  exec_op;
    logic [31:0] exec_pc, exec_rs1, exec_rs2, exec_imm;
    logic [4:0]  exec_name;

    int tests = 0;
    int fails = 0;

    alu_rs_station #(.RS_SIZE(16), .TAG_WIDTH(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_pc(issue_pc),
        .issue_imm(issue_imm), .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_rj(issue_rj),
        .issue_rk(issue_rk), .issue_dest(issue_dest), .rs_full(rs_full),
        .alu_valid_in(alu_valid_in), .alu_name_in(alu_name_in),
        .alu_result_in(alu_result_in), .lsb_valid_in(lsb_valid_in),
        .lsb_name_in(lsb_name_in), .lsb_result_in(lsb_result_in),
        .exec_valid(exec_valid), .exec_op(exec_op), .exec_pc(exec_pc),
        .exec_rs1(exec_rs1), .exec_rs2(exec_rs2), .exec_imm(exec_imm),
        .exec_name(exec_name)
    );

    always #5 clk_in = ~clk_in;

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_in;
        issue_valid  = 1'b0;
        alu_valid_in = 1'b0;
        lsb_valid_in = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic drive_issue(input logic [6:0] op, input logic [31:0] pc, vj, vk, imm,
                               input logic [4:0] qj, qk, input logic rj, rk,
                               input logic [4:0] dest);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_pc    = pc;
        issue_vj    = vj;
        issue_vk    = vk;
        issue_imm   = imm;
        issue_qj    = qj;
        issue_qk    = qk;
        issue_rj    = rj;
        issue_rk    = rk;
        issue_dest  = dest;
    endtask

    task automatic test_reset;
        rst_in = 1'b0; rdy_in = 1'b1; idle_in();
        drive_issue(7'h0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        issue_valid = 1'b0;
        alu_name_in = 0; lsb_name_in = 0; alu_result_in = 0; lsb_result_in = 0;
        #1 rst_in = 1'b1;
        #1;
        tests++; if (exec_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", exec_valid); end
        tests++; if (rs_full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", rs_full); end
        tests++; if (exec_name !== 5'd0 || exec_rs1 !== 32'd0) begin fails++; $display("FAIL reset_data: name %0d rs1 %h want 0 0", exec_name, exec_rs1); end
        step();
        step();
        rst_in = 1'b0;
        step();
    endtask

    task automatic test_addi;
        drive_issue(7'h13, 32'h100, 32'd5, 32'd0, 32'd7, 0, 0, 1'b1, 1'b1, 5'd3);
        step();
        idle_in();
        tests++; if (exec_valid !== 1'b0) begin fails++; $display("FAIL addi_early: got %b want 0", exec_valid); end
        step();
        tests++; if (exec_valid !== 1'b1 || exec_rs1 !== 32'd5 || exec_imm !== 32'd7 || exec_name !== 5'd3)
            begin fails++; $display("FAIL addi_exec: v %b rs1 %h imm %h name %0d want 1 5 7 3", exec_valid, exec_rs1, exec_imm, exec_name); end
        tests++; if (exec_op !== 7'h13 || exec_pc !== 32'h100) begin fails++; $display("FAIL addi_oppc: op %h pc %h want 13 100", exec_op, exec_pc); end
        step();
        tests++; if (exec_valid !== 1'b0 || exec_name !== 5'd3) begin fails++; $display("FAIL addi_after: v %b name %0d want 0 3", exec_valid, exec_name); end
    endtask

    task automatic test_back_to_back;
        drive_issue(7'h13, 32'h200, 32'd11, 32'd0, 32'd1, 0, 0, 1'b1, 1'b1, 5'd1);
        step();
        drive_issue(7'h13, 32'h204, 32'd22, 32'd0, 32'd2, 0, 0, 1'b1, 1'b1, 5'd2);
        step();
        idle_in();
        tests++; if (exec_valid !== 1'b1 || exec_name !== 5'd1 || exec_rs1 !== 32'd11) begin fails++; $display("FAIL b2b_first: v %b name %0d rs1 %0d want 1 1 11", exec_valid, exec_name, exec_rs1); end
        step();
        tests++; if (exec_valid !== 1'b1 || exec_name !== 5'd2 || exec_rs1 !== 32'd22) begin fails++; $display("FAIL b2b_second: v %b name %0d rs1 %0d want 1 2 22", exec_valid, exec_name, exec_rs1); end
        step();
        tests++; if (exec_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b want 0", exec_valid); end
    endtask

    task automatic test_wakeup;
        drive_issue(7'h33, 32'h300, 32'd0, 32'h22, 32'd0, 5'd4, 0, 1'b0, 1'b1, 5'd8);
        step();
        idle_in();
        step();
        tests++; if (exec_valid !== 1'b0) begin fails++; $display("FAIL wake_wait: got %b want 0", exec_valid); end
        alu_valid_in = 1'b1; alu_name_in = 5'd4; alu_result_in = 32'h10;
        step();
        alu_valid_in = 1'b0;
`ifndef RS_FWD_EN
        tests++; if (exec_valid !== 1'b0) begin fails++; $display("FAIL wake_capture: got %b want 0", exec_valid); end
        step();
`endif
        tests++; if (exec_valid !== 1'b1 || exec_rs1 !== 32'h10 || exec_rs2 !== 32'h22 || exec_name !== 5'd8)
            begin fails++; $display("FAIL wake_exec: v %b rs1 %h rs2 %h name %0d want 1 10 22 8", exec_valid, exec_rs1, exec_rs2, exec_name); end
        step();
    endtask

    task automatic test_full;
        for (int i = 0; i < 16; i++) begin
            drive_issue(7'h33, 32'h400 + 32'(i), 32'd0, 32'd0, 32'd0, 5'(16 + i), 0, 1'b0, 1'b1, 5'(i));
            step();
        end
        idle_in();
        tests++; if (rs_full !== 1'b1) begin fails++; $display("FAIL full_set: got %b want 1", rs_full); end
        drive_issue(7'h13, 32'h500, 32'd1, 32'd1, 32'd0, 0, 0, 1'b1, 1'b1, 5'd30);
        step();
        idle_in();
        tests++; if (rs_full !== 1'b1 || exec_valid !== 1'b0) begin fails++; $display("FAIL full_drop: full %b v %b want 1 0", rs_full, exec_valid); end
        lsb_valid_in = 1'b1; lsb_name_in = 5'd25; lsb_result_in = 32'h99;
        step();
        lsb_valid_in = 1'b0;
`ifndef RS_FWD_EN
        tests++; if (exec_valid !== 1'b0 || rs_full !== 1'b1) begin fails++; $display("FAIL full_capture: v %b full %b want 0 1", exec_valid, rs_full); end
        step();
`endif
        tests++; if (exec_valid !== 1'b1 || exec_name !== 5'd9 || exec_rs1 !== 32'h99 || rs_full !== 1'b0)
            begin fails++; $display("FAIL full_wake9: v %b name %0d rs1 %h full %b want 1 9 99 0", exec_valid, exec_name, exec_rs1, rs_full); end
        drive_issue(7'h13, 32'h600, 32'h17, 32'd0, 32'd0, 0, 0, 1'b1, 1'b1, 5'd17);
        step();
        idle_in();
        tests++; if (rs_full !== 1'b1 || exec_valid !== 1'b0) begin fails++; $display("FAIL full_refill: full %b v %b want 1 0", rs_full, exec_valid); end
        step();
        tests++; if (exec_valid !== 1'b1 || exec_name !== 5'd17 || exec_rs1 !== 32'h17 || rs_full !== 1'b0)
            begin fails++; $display("FAIL full_slot9: v %b name %0d rs1 %h full %b want 1 17 17 0", exec_valid, exec_name, exec_rs1, rs_full); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        tests++; if (rs_full !== 1'b0 || exec_valid !== 1'b0) begin fails++; $display("FAIL full_flush: full %b v %b want 0 0", rs_full, exec_valid); end
    endtask

    task automatic test_issue_capture;
        drive_issue(7'h33, 32'h700, 32'd0, 32'd3, 32'd0, 5'd6, 0, 1'b0, 1'b1, 5'd12);
        alu_valid_in = 1'b1; alu_name_in = 5'd6; alu_result_in = 32'hABCD;
        step();
        idle_in();
        tests++; if (exec_valid !== 1'b0) begin fails++; $display("FAIL icap_early: got %b want 0", exec_valid); end
        step();
        tests++; if (exec_valid !== 1'b1 || exec_rs1 !== 32'hABCD || exec_rs2 !== 32'd3 || exec_name !== 5'd12)
            begin fails++; $display("FAIL icap_exec: v %b rs1 %h rs2 %h name %0d want 1 abcd 3 12", exec_valid, exec_rs1, exec_rs2, exec_name); end
        step();
    endtask

    task automatic test_clear;
        for (int i = 0; i < 5; i++) begin
            drive_issue(7'h33, 32'h800, 32'd0, 32'd0, 32'd0, 5'(20 + i), 0, 1'b0, 1'b1, 5'(20 + i));
            step();
        end
        idle_in();
        alu_valid_in = 1'b1; alu_name_in = 5'd20; alu_result_in = 32'd1;
        lsb_valid_in = 1'b1; lsb_name_in = 5'd21; lsb_result_in = 32'd2;
`ifndef RS_FWD_EN
        step();
        idle_in();
        tests++; if (exec_valid !== 1'b0) begin fails++; $display("FAIL clear_pre: got %b want 0", exec_valid); end
`endif
        clear = 1'b1;
        step();
        idle_in();
        tests++; if (exec_valid !== 1'b0 || rs_full !== 1'b0) begin fails++; $display("FAIL clear_now: v %b full %b want 0 0", exec_valid, rs_full); end
        for (int k = 0; k < 4; k++) begin
            alu_valid_in = 1'b1; alu_name_in = 5'(20 + k);
            lsb_valid_in = 1'b1; lsb_name_in = 5'(24 - k);
            step();
            tests++; if (exec_valid !== 1'b0) begin fails++; $display("FAIL clear_ghost: cycle %0d v %b name %0d want v 0", k, exec_valid, exec_name); end
        end
        idle_in();
        step();
    endtask

    task automatic test_stall;
        rdy_in = 1'b0;
        drive_issue(7'h13, 32'h900, 32'h55, 32'd0, 32'd0, 0, 0, 1'b1, 1'b1, 5'd5);
        step();
        idle_in();
        step();
        rdy_in = 1'b1;
        step();
        tests++; if (exec_valid !== 1'b0) begin fails++; $display("FAIL stall_noissue: got %b want 0", exec_valid); end
        drive_issue(7'h13, 32'h904, 32'h66, 32'd0, 32'd0, 0, 0, 1'b1, 1'b1, 5'd6);
        step();
        idle_in();
        rdy_in = 1'b0;
        step();
        tests++; if (exec_valid !== 1'b0) begin fails++; $display("FAIL stall_freeze: got %b want 0", exec_valid); end
        rdy_in = 1'b1;
        step();
        tests++; if (exec_valid !== 1'b1 || exec_name !== 5'd6 || exec_rs1 !== 32'h66) begin fails++; $display("FAIL stall_resume: v %b name %0d rs1 %h want 1 6 66", exec_valid, exec_name, exec_rs1); end
        step();
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i < 3; i++) begin
            drive_issue(7'h33, 32'hA00, 32'd0, 32'd0, 32'd0, 5'(10 + i), 0, 1'b0, 1'b1, 5'(1 + i));
            step();
        end
        drive_issue(7'h13, 32'hA10, 32'h44, 32'd0, 32'd0, 0, 0, 1'b1, 1'b1, 5'd4);
        step();
        idle_in();
        step();
        tests++; if (exec_valid !== 1'b1 || exec_name !== 5'd4) begin fails++; $display("FAIL mrst_pre: v %b name %0d want 1 4", exec_valid, exec_name); end
        #2 rst_in = 1'b1;
        #1;
        tests++; if (exec_valid !== 1'b0 || rs_full !== 1'b0 || exec_name !== 5'd0) begin fails++; $display("FAIL mrst_async: v %b full %b name %0d want 0 0 0", exec_valid, rs_full, exec_name); end
        #1 rst_in = 1'b0;
        alu_valid_in = 1'b1; alu_name_in = 5'd10;
        lsb_valid_in = 1'b1; lsb_name_in = 5'd11;
        step();
        idle_in();
        step();
        tests++; if (exec_valid !== 1'b0) begin fails++; $display("FAIL mrst_stale: v %b name %0d want v 0", exec_valid, exec_name); end
        drive_issue(7'h13, 32'hA20, 32'h77, 32'd0, 32'd0, 0, 0, 1'b1, 1'b1, 5'd7);
        step();
        idle_in();
        step();
        tests++; if (exec_valid !== 1'b1 || exec_name !== 5'd7 || exec_rs1 !== 32'h77) begin fails++; $display("FAIL mrst_post: v %b name %0d rs1 %h want 1 7 77", exec_valid, exec_name, exec_rs1); end
        step();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_wakeup();
        test_full();
        test_issue_capture();
        test_clear();
        test_stall();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
